itcm_loader: RTL and testbench

- Boot-time program loader that sits upstream of the CPU/SRAM pair.
- Receives a byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes each word into the ITCM write port and holds the CPU in reset until the image is fully loaded.
- Releases the CPU only on a good load; an errored load leaves it in reset.

---
 rtl/itcm_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_itcm_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_loader.sv
// itcm_loader: boot-time ITCM image loader.
//
// Consumes a byte stream (valid/ready), parses a 16-bit little-endian word
// count N, assembles 4*N data bytes into little-endian 32-bit words and
// writes each word to the ITCM write port. The CPU is held in reset
// (cpu_rst_n=0) until a load completes without error.
//
// Optional build macro: ITCM_LOADER_CSUM_EN
//   When defined, one trailing checksum byte (8-bit sum of all data bytes)
//   is expected after the data; a mismatch ends the load in ERR.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse; starts a load from IDLE/DONE/ERR
//   in_valid/in_data  byte stream input
//   in_ready          byte accepted when in_valid && in_ready
//   ram_we/ram_addr/ram_din/ram_wem  ITCM write port (one cycle per word)
//   cpu_rst_n         CPU reset, active-low (1 only after a good load)
//   busy/done/err     load status
module itcm_loader #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32   // fixed at 32: four bytes per word
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [3:0]        ram_wem,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Word counters are wide enough for any 16-bit N plus one.
  localparam int unsigned CNT_W = 17;
  // Capacity in words, held wide so ADDR_W up to 32 compares correctly.
  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_FIN,
    S_DONE,
    S_ERR
`ifdef ITCM_LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        n_q, n_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   rx_words_q, rx_words_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [23:0]        word_q, word_d;
  logic               ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  ram_din_q, ram_din_d;
`ifdef ITCM_LOADER_CSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic        accept;
  logic [15:0] hdr_n;
  logic        all_rx;

  assign hdr_n  = {in_data, n_q[7:0]};
  // Once every data byte is in, stop accepting until the checksum phase.
  assign all_rx = (rx_words_q == CNT_W'(n_q));
  assign accept = in_valid && in_ready;

  // Status outputs decode directly from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst_n = 1'b0;
    unique case (state_q)
      S_HDR0, S_HDR1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DATA: begin
        in_ready = !all_rx;
        busy     = 1'b1;
      end
      S_FIN: busy = 1'b1;
`ifdef ITCM_LOADER_CSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_cnt_d = byte_cnt_q;
    rx_words_d = rx_words_q;
    word_cnt_d = word_cnt_q;
    word_d     = word_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
`ifdef ITCM_LOADER_CSUM_EN
    sum_d      = sum_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR0;
          n_d        = '0;
          byte_cnt_d = '0;
          rx_words_d = '0;
          word_cnt_d = '0;
`ifdef ITCM_LOADER_CSUM_EN
          sum_d      = '0;
`endif
        end
      end

      S_HDR0: begin
        if (accept) begin
          n_d[7:0] = in_data;
          state_d  = S_HDR1;
        end
      end

      S_HDR1: begin
        if (accept) begin
          n_d = hdr_n;
          if ({17'd0, hdr_n} > CAP) begin
            state_d = S_ERR;
          end else if (hdr_n == 16'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef ITCM_LOADER_CSUM_EN
          sum_d      = sum_q + in_data;
`endif
          unique case (byte_cnt_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            default: begin
              // Fourth byte: hand the full word to the output register so
              // the next word can start assembling during the write cycle.
              ram_we_d   = 1'b1;
              ram_addr_d = ADDR_W'(word_cnt_q);
              ram_din_d  = {in_data, word_q};
              rx_words_d = rx_words_q + CNT_W'(1);
            end
          endcase
        end
        if (ram_we_q) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_q + CNT_W'(1) == CNT_W'(n_q)) begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
`ifdef ITCM_LOADER_CSUM_EN
        state_d = S_CSUM;
`else
        state_d = S_DONE;
`endif
      end

`ifdef ITCM_LOADER_CSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      byte_cnt_q <= '0;
      rx_words_q <= '0;
      word_cnt_q <= '0;
      word_q     <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
`ifdef ITCM_LOADER_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_cnt_q <= byte_cnt_d;
      rx_words_q <= rx_words_d;
      word_cnt_q <= word_cnt_d;
      word_q     <= word_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
`ifdef ITCM_LOADER_CSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_wem  = ram_we_q ? 4'hF : 4'h0;

endmodule

// File: tb/tb_itcm_loader.sv
module tb_itcm_loader;

  localparam int unsigned AW = 2;
`ifdef ITCM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk, rst, start, in_valid, in_ready;
  logic [7:0]    in_data;
  logic          ram_we, cpu_rst_n, busy, done, err;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [3:0]    ram_wem;

  itcm_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_wem(ram_wem),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct { int unsigned a; logic [31:0] d; } wr_t;
  wr_t wlog[$];

  // Reference model: tracks the load as a byte position in the stream.
  bit          m_load, m_done, m_err, m_tail, m_we;
  int unsigned m_pos, m_n, m_k, m_addr;
  logic [31:0] m_word, m_din;
  logic [7:0]  m_sum;

  initial begin
    m_load = 0; m_done = 0; m_err = 0; m_tail = 0; m_we = 0;
    m_pos = 0; m_n = 0; m_k = 0; m_addr = 0; m_word = '0; m_din = '0; m_sum = '0;
  end

  always @(negedge clk) begin
    bit          we_next, exp_ready;
    int unsigned fin_k, idx;
    logic [7:0]  b;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_ram_wem", ram_wem, 0);
      chk("rst_cpu_rst_n", cpu_rst_n, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      m_load = 0; m_done = 0; m_err = 0; m_tail = 0; m_we = 0; m_pos = 0;
    end else begin
      fin_k = (m_n == 0) ? 1 : 2;
      exp_ready = m_load && (m_tail ? (CSUM && m_k > fin_k) : 1'b1);
      chk("ram_we", ram_we, m_we);
      if (m_we) begin
        chk("ram_addr", ram_addr, m_addr % (1 << AW));
        chk("ram_din", ram_din, m_din);
        chk("ram_wem", ram_wem, 4'hF);
        wlog.push_back('{ram_addr, ram_din});
      end else begin
        chk("ram_wem_idle", ram_wem, 4'h0);
      end
      chk("busy", busy, m_load);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("cpu_rst_n", cpu_rst_n, m_done);
      chk("in_ready", in_ready, exp_ready);

      we_next = 0;
      b = in_data;
      if (start && !m_load) begin
        m_load = 1; m_pos = 0; m_n = 0; m_done = 0; m_err = 0; m_sum = '0; m_tail = 0;
      end else if (m_load && m_tail) begin
        if (!CSUM && m_k == fin_k) begin
          m_load = 0; m_done = 1; m_tail = 0;
        end else if (CSUM && in_valid && in_ready) begin
          m_load = 0; m_tail = 0;
          if (b == m_sum) m_done = 1; else m_err = 1;
        end
        m_k++;
      end else if (m_load && in_valid && in_ready) begin
        if (m_pos == 0) begin
          m_n = {24'd0, b};
        end else if (m_pos == 1) begin
          m_n = m_n + ({24'd0, b} << 8);
          if (m_n > (1 << AW)) begin
            m_load = 0; m_err = 1;
          end else if (m_n == 0) begin
            m_tail = 1; m_k = 1;
          end
        end else begin
          idx = m_pos - 2;
          m_word[8*(idx%4) +: 8] = b;
          m_sum = m_sum + b;
          if (idx % 4 == 3) begin
            we_next = 1; m_addr = idx / 4; m_din = m_word;
          end
          if (idx == 4*m_n - 1) begin
            m_tail = 1; m_k = 1;
          end
        end
        m_pos++;
      end
      m_we = we_next;
    end
  end

  logic [31:0] img[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] bv, input int unsigned gap);
    int unsigned t;
    bit acc;
    t = 0;
    acc = 0;
    while ($urandom_range(99) < gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = bv;
    while (!acc && t <= 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      t++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int unsigned t;
    t = 0;
    @(negedge clk);
    while (!(done || err) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("end_timeout", 0, 1);
  endtask

  task automatic run_load(input int unsigned n, input int unsigned gap, input bit bad_sum);
    logic [7:0]  q[$];
    logic [7:0]  s, bv;
    logic [31:0] w;
    int unsigned base;
    bit over, exp_err;
    over = n > (1 << AW);
    w = n;
    q.push_back(w[7:0]);
    q.push_back(w[15:8]);
    s = '0;
    if (!over) begin
      for (int unsigned i = 0; i < n; i++) begin
        w = img[i];
        for (int unsigned j = 0; j < 4; j++) begin
          bv = w[8*j +: 8];
          q.push_back(bv);
          s = s + bv;
        end
      end
      if (CSUM) q.push_back(bad_sum ? s + 8'd1 : s);
    end
    exp_err = over || (CSUM && bad_sum);
    base = wlog.size();
    if ($urandom_range(1) == 1) begin
      // present the first header byte early; it must not be taken before start
      in_valid = 1'b1;
      in_data  = q[0];
      tick();
      tick();
    end
    do_start();
    foreach (q[i]) send(q[i], gap);
    wait_end();
    chk("end_done", done, !exp_err);
    chk("end_err", err, exp_err);
    chk("end_cpu_rst_n", cpu_rst_n, !exp_err);
    chk("end_busy", busy, 0);
    chk("wr_count", wlog.size() - base, over ? 0 : n);
    if (!over) begin
      for (int unsigned i = 0; i < n && base + i < wlog.size(); i++) begin
        chk("wr_addr", wlog[base+i].a, i);
        chk("wr_data", wlog[base+i].d, img[i]);
      end
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] s;
    int unsigned n, base;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("idle_cpu_rst_n", cpu_rst_n, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_ram_we", ram_we, 0);

    // Reference image, contiguous and with random gaps
    img = {32'h12345678, 32'hDEADBEEF};
    run_load(2, 0, 0);
    run_load(2, 50, 0);

    // Header bounds: oversize (low and high byte), exactly full, empty
    run_load(5, 0, 0);
    run_load(256, 20, 0);
    img = {32'h11111111, 32'h22222222, 32'h33333333, 32'hCAFEF00D};
    run_load(4, 0, 0);
    run_load(0, 0, 0);

    // start during DATA is ignored
    base = wlog.size();
    do_start();
    send(8'h01, 0); send(8'h00, 0); send(8'hAA, 0); send(8'hBB, 0);
    do_start();
    chk("start_ignored_busy", busy, 1);
    send(8'hCC, 0); send(8'hDD, 0);
    s = 8'hAA + 8'hBB + 8'hCC + 8'hDD;
    if (CSUM) send(s, 0);
    wait_end();
    chk("ign_done", done, 1);
    chk("ign_wr_count", wlog.size() - base, 1);
    if (wlog.size() > base) chk("ign_wr_data", wlog[base].d, 32'hDDCCBBAA);
    tick();

    // reset mid-word
    do_start();
    send(8'h01, 0); send(8'h00, 0); send(8'h11, 0); send(8'h22, 0);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_ram_din", ram_din, 0);
    chk("abort_cpu_rst_n", cpu_rst_n, 0);
    tick();
    rst = 1'b0;
    tick();
    img = {32'hDDCCBBAA};
    run_load(1, 30, 0);

`ifdef ITCM_LOADER_CSUM_EN
    img = {32'h04030201};
    run_load(1, 0, 0);
    run_load(1, 0, 1);
`endif

    // Randomized loads
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(5) == 0) begin
        case ($urandom_range(3))
          0: n = 5;
          1: n = 16;
          2: n = 256;
          default: n = 65535;
        endcase
      end else begin
        n = $urandom_range(1 << AW);
      end
      img = {};
      for (int unsigned i = 0; i < (1 << AW); i++) img.push_back($urandom);
      run_load(n, $urandom_range(2) * 30, 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
